// File: rtl/mem_bridge.sv
// Converts the core's level-held mem_read/mem_write into one word-aligned transaction on a
// single-outstanding req/gnt/rvalid bus, with lane steering, load extension and error completion.
module mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [2:0]        mem_size,
    output logic [31:0]       mem_rdata,
    output logic              mem_resp,
    output logic              mem_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [TO_W:0] TO_LIM = TIMEOUT[TO_W:0];

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [2:0]          r_size;
    logic [1:0]          r_off;
    logic [ADDR_W-3:0]   r_addr;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [TO_W-1:0]     r_cnt;
    logic [31:0]         r_rdata;

    logic                w_any;
    logic                w_size_ok;
    logic                w_align_ok;
    logic                w_req_err;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [31:0]         w_shift;
    logic [31:0]         w_ext;
    logic [TO_W:0]       w_cnt_inc;
    logic                w_busy;
    logic                w_busy_nxt;
    logic                w_to;

    assign w_any     = mem_read | mem_write;
    assign w_req_err = (mem_read & mem_write) | ~w_size_ok | ~w_align_ok;

    // Request decode: legality, alignment, byte enables and lane-replicated store data
    always_comb begin
        w_size_ok  = 1'b0;
        w_align_ok = 1'b0;
        w_be       = 4'hF;
        w_wdata    = mem_wdata;
        case (mem_size)
            3'b000, 3'b001, 3'b010: w_size_ok = 1'b1;
            3'b100, 3'b101:         w_size_ok = ~mem_write;
            default:                w_size_ok = 1'b0;
        endcase
        case (mem_size[1:0])
            2'b00: begin
                w_align_ok = 1'b1;
                w_be       = 4'b0001 << mem_addr[1:0];
                w_wdata    = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                w_align_ok = ~mem_addr[0];
                w_be       = 4'b0011 << mem_addr[1:0];
                w_wdata    = {2{mem_wdata[15:0]}};
            end
            2'b10:   w_align_ok = (mem_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b0;
        endcase
    end

    assign w_shift = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = bus_rdata;
        case (r_size[1:0])
            2'b00:   w_ext = {{24{~r_size[2] & w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_ext = {{16{~r_size[2] & w_shift[15]}}, w_shift[15:0]};
            default: w_ext = bus_rdata;
        endcase
    end

    assign w_busy     = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_busy_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT);
    assign w_cnt_inc  = {1'b0, r_cnt} + {{TO_W{1'b0}}, 1'b1};
    assign w_to       = w_busy && (w_cnt_inc >= TO_LIM);

    // A bus event (gnt in REQ, rvalid in WAIT) takes priority over a timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = w_req_err ? S_RESP : S_REQ;
            S_REQ: begin
                if (bus_gnt)   w_state_nxt = r_we ? S_RESP : S_WAIT;
                else if (w_to) w_state_nxt = S_RESP;
            end
            S_WAIT:  if (bus_rvalid || w_to) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_DRAIN;
            S_DRAIN: if (!w_any) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_off   <= 2'b00;
            r_addr  <= '0;
            r_be    <= 4'h0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_busy && w_busy_nxt) ? w_cnt_inc[TO_W-1:0] : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_we    <= mem_write;
                        r_size  <= mem_size;
                        r_off   <= mem_addr[1:0];
                        r_addr  <= mem_addr[ADDR_W-1:2];
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_err   <= w_req_err;
                    end
                end
                S_REQ:   if (!bus_gnt && w_to) r_err <= 1'b1;
                S_WAIT: begin
                    if (bus_rvalid) r_rdata <= w_ext;
                    else if (w_to)  r_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // bus_req stays high with stable addr/we/be/wdata until the cycle bus_gnt is seen with it
    assign bus_req   = (r_state == S_REQ);
    assign bus_we    = bus_req & r_we;
    assign bus_addr  = bus_req ? {r_addr, 2'b00} : '0;
    assign bus_be    = bus_req ? r_be : 4'h0;
    assign bus_wdata = bus_req ? r_wdata : 32'h0;
    assign mem_resp  = (r_state == S_RESP);
    assign mem_err   = mem_resp & r_err;
    assign mem_rdata = r_rdata;
    assign dbg_state = r_state;

endmodule
